// File: rtl/stage_writeback_ext.sv
// Writeback stage: registers the selected result into WB with load extraction,
// misalignment detection, stall/flush control and a retired-instruction counter.
module stage_writeback_ext #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [1:0]            mem_result_src,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_read_data,
  input  logic [XLEN-1:0]       mem_instr_addr_plus,
  input  logic                  mem_regfile_wr_enable,
  input  logic [2:0]            mem_load_funct3,
  input  logic                  wb_stall,
  input  logic                  wb_flush,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_write_data,
  output logic                  wb_regfile_wr_enable,
  output logic                  wb_misaligned,
  output logic [CNT_W-1:0]      wb_instret
);

  localparam int unsigned OFS_W = $clog2(XLEN / 8);

  logic [OFS_W-1:0]      off;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       load_val;
  logic                  load_mis;
  logic                  misaligned;
  logic [XLEN-1:0]       sel_data;

  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic                  we_q, we_d;
  logic                  mis_q, mis_d;
  logic [CNT_W-1:0]      instret_q, instret_d;

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    off      = mem_alu_result[OFS_W-1:0];
    shifted  = mem_read_data >> {off, 3'b000};
    load_val = mem_read_data;
    load_mis = 1'b0;
    case (mem_load_funct3)
      3'b000: load_val = XLEN'($signed(shifted[7:0]));
      3'b100: load_val = XLEN'(shifted[7:0]);
      3'b001: begin
        load_val = XLEN'($signed(shifted[15:0]));
        load_mis = off[0];
      end
      3'b101: begin
        load_val = XLEN'(shifted[15:0]);
        load_mis = off[0];
      end
      3'b010: begin
        load_val = XLEN'($signed(shifted[31:0]));
        load_mis = (off[1:0] != 2'b00);
      end
      3'b110: begin
        if (XLEN == 64) begin
          load_val = XLEN'(shifted[31:0]);
          load_mis = (off[1:0] != 2'b00);
        end
      end
      3'b011: begin
        if (XLEN == 64) begin
          load_val = mem_read_data;
          load_mis = (off != '0);
        end
      end
      default: ;
    endcase
  end

  // Result select and misalignment qualification.
  always_comb begin
    misaligned = mem_valid && (mem_result_src == 2'b01) && load_mis;
    case (mem_result_src)
      2'b01:   sel_data = load_val;
      2'b10:   sel_data = mem_instr_addr_plus;
      default: sel_data = mem_alu_result;
    endcase
  end

  // Next-state: flush beats stall, stall holds everything.
  always_comb begin
    valid_d   = valid_q;
    rd_d      = rd_q;
    data_d    = data_q;
    we_d      = we_q;
    mis_d     = mis_q;
    instret_d = instret_q;
    if (wb_flush) begin
      valid_d = 1'b0;
      rd_d    = '0;
      data_d  = '0;
      we_d    = 1'b0;
      mis_d   = 1'b0;
    end else if (!wb_stall) begin
      valid_d = mem_valid;
      rd_d    = mem_rd;
      data_d  = sel_data;
      we_d    = mem_valid && mem_regfile_wr_enable && (mem_rd != '0) && !misaligned;
      mis_d   = misaligned;
      if (mem_valid) begin
        instret_d = instret_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      we_q      <= we_d;
      mis_q     <= mis_d;
      instret_q <= instret_d;
    end
  end

  assign wb_valid             = valid_q;
  assign wb_rd                = rd_q;
  assign wb_write_data        = data_q;
  assign wb_regfile_wr_enable = we_q;
  assign wb_misaligned        = mis_q;
  assign wb_instret           = instret_q;

endmodule
